// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch
//  Purpose  : Instruction-fetch stage. Owns the PC, fetches 32-bit words
//             from the memory controller and presents them to the IF/ID
//             register through if_pc/if_ins. The IF/ID register latches on
//             every edge with stall=0, so NOP_PC/NOP_INS are driven whenever
//             no fetched word is pending, which keeps instructions from being
//             latched twice. Honours stall and jump redirects.
//  Ports    : clk_in    - clock, all state on rising edge
//             rst_in    - asynchronous active-high reset
//             rdy_in    - chip ready, 0 freezes every register
//             stall     - 1 = IF/ID does not latch this edge
//             jump      - redirect request, highest priority
//             jump_pc   - redirect target, bits [1:0] ignored
//             mem_req   - registered fetch request, held until mem_ready
//             mem_addr  - fetch address, stable while mem_req=1
//             mem_ready - one-cycle pulse, mem_data valid, ends transaction
//             mem_data  - fetched word
//             if_pc     - PC of presented word, else NOP_PC
//             if_ins    - presented word, else NOP_INS
//  Options  : ICACHE_EN - adds a direct-mapped instruction cache of
//             2^ICACHE_IDX_W one-word lines and a LOOKUP state.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_PC       = 32'h0000_0000,
  parameter logic [31:0] NOP_INS      = 32'h0000_0013,
  parameter int          ICACHE_IDX_W = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_HOLD  = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
`ifdef ICACHE_EN
  localparam logic [2:0] c_LOOKUP  = 3'd4;
  // With the cache every fresh fetch first probes the cache.
  localparam logic [2:0] c_REFETCH = c_LOOKUP;
  localparam int         c_LINES   = 1 << ICACHE_IDX_W;
  localparam int         c_TAG_W   = 30 - ICACHE_IDX_W;
`else
  localparam logic [2:0] c_REFETCH = c_FETCH;
`endif

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        r_valid;
  logic [31:0] r_cap_pc;
  logic [31:0] r_cap_ins;

  logic [2:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_valid_nxt;
  logic        w_cap_en;
  logic [31:0] w_cap_ins;
  logic        w_fill_en;
  logic        w_mem_req_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic        w_hit;
  logic [31:0] w_hit_data;

  logic [31:0] w_jump_tgt;
  logic [31:0] w_pc_inc;
  logic        w_unused;

  assign w_jump_tgt = {jump_pc[31:2], 2'b00};
  assign w_pc_inc   = r_pc + 32'd4;
  assign w_unused   = ^{jump_pc[1:0], (ICACHE_IDX_W > 0)};

`ifdef ICACHE_EN
  logic [31:0]              r_line_data [c_LINES];
  logic [c_TAG_W-1:0]       r_line_tag  [c_LINES];
  logic [c_LINES-1:0]       r_line_vld;
  logic [ICACHE_IDX_W-1:0]  w_idx;
  logic [c_TAG_W-1:0]       w_tag;

  assign w_idx      = r_pc[ICACHE_IDX_W+1:2];
  assign w_tag      = r_pc[31:ICACHE_IDX_W+2];
  assign w_hit      = r_line_vld[w_idx] && (r_line_tag[w_idx] == w_tag);
  assign w_hit_data = r_line_data[w_idx];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_line_vld <= '0;
    end else if (rdy_in && w_fill_en) begin
      r_line_vld[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && w_fill_en) begin
      r_line_data[w_idx] <= mem_data;
      r_line_tag[w_idx]  <= w_tag;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = NOP_INS;
`endif

  // State and datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= c_IDLE;
      r_pc       <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_valid    <= 1'b0;
      r_cap_pc   <= NOP_PC;
      r_cap_ins  <= NOP_INS;
    end else if (rdy_in) begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_valid    <= w_valid_nxt;
      if (w_cap_en) begin
        r_cap_pc  <= r_pc;
        r_cap_ins <= w_cap_ins;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: w_state_nxt = c_REFETCH;
      c_FETCH: begin
        if (jump) begin
          // An in-flight transaction cannot be aborted; drain it unless it
          // completes on this very edge.
          w_state_nxt = mem_ready ? c_FETCH : c_DRAIN;
        end else if (mem_ready) begin
          w_state_nxt = c_HOLD;
        end
      end
      c_HOLD: begin
        if (jump || !stall) begin
          w_state_nxt = c_REFETCH;
        end
      end
      c_DRAIN: begin
        // A jump arriving with the final mem_ready simply retargets the
        // fetch that follows the drain.
        if (mem_ready) begin
          w_state_nxt = c_FETCH;
        end
      end
`ifdef ICACHE_EN
      c_LOOKUP: begin
        if (!jump) begin
          w_state_nxt = w_hit ? c_HOLD : c_FETCH;
        end
      end
`endif
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_cap_en    = 1'b0;
    w_cap_ins   = mem_data;
    w_fill_en   = 1'b0;
    if (jump) begin
      w_pc_nxt    = w_jump_tgt;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        c_FETCH: begin
          if (mem_ready) begin
            w_cap_en    = 1'b1;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_fill_en   = 1'b1;
          end
        end
        c_HOLD: begin
          if (!stall) begin
            w_valid_nxt = 1'b0;
          end
        end
`ifdef ICACHE_EN
        c_LOOKUP: begin
          if (w_hit) begin
            w_cap_en    = 1'b1;
            w_cap_ins   = w_hit_data;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_inc;
          end
        end
`endif
        default: ;
      endcase
    end

    w_mem_req_nxt = (w_state_nxt == c_FETCH) || (w_state_nxt == c_DRAIN);
    // Entering or staying in FETCH always addresses the (possibly new) PC;
    // DRAIN keeps the old address until the outstanding transaction ends.
    w_mem_addr_nxt = (w_state_nxt == c_FETCH) ? w_pc_nxt : r_mem_addr;
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign if_pc    = r_valid ? r_cap_pc  : NOP_PC;
  assign if_ins   = r_valid ? r_cap_ins : NOP_INS;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch
//  Purpose  : Directed bench for if_fetch. The stimulus thread drives the
//             memory/pipeline inputs and checks the bus side; every word it
//             expects the IF/ID register to latch is queued, and a monitor
//             pops and compares whenever a word is latched downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam logic [31:0] c_NOP_INS = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } word_t;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        stall;
  logic        jump;
  logic [31:0] jump_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] if_pc;
  logic [31:0] if_ins;

  int    n_checks = 0;
  int    n_errors = 0;
  word_t sb_q[$];
  word_t sb_w;

  if_fetch dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .stall     (stall),
    .jump      (jump),
    .jump_pc   (jump_pc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_data  (mem_data),
    .if_pc     (if_pc),
    .if_ins    (if_ins)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] ins);
    sb_q.push_back({pc, ins});
  endtask

  // Monitor: the IF/ID register latches a real word on an edge with
  // rdy_in=1, stall=0 and no redirect flushing it.
  always @(negedge clk_in) begin
    if (!rst_in && rdy_in && !stall && !jump && if_ins !== c_NOP_INS) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ins", if_ins, c_NOP_INS);
      end else begin
        sb_w = sb_q.pop_front();
        check("sb_pc", if_pc, sb_w.pc);
        check("sb_ins", if_ins, sb_w.ins);
      end
    end
  end

  initial begin
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    stall     = 1'b0;
    jump      = 1'b0;
    jump_pc   = 32'h0;
    mem_ready = 1'b0;
    mem_data  = 32'h0;
    repeat (2) tick();
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_if_pc", if_pc, 32'h0);
    check("reset_if_ins", if_ins, c_NOP_INS);
    rst_in = 1'b0;

`ifdef ICACHE_EN
    // IDLE -> LOOKUP (miss on empty cache) -> FETCH at 0
    check("idle_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("lookup_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("miss_req", {31'd0, mem_req}, 32'd1);
    check("miss_addr", mem_addr, 32'h0);
    // Redirect to 0x40 through a drain, then fill line for 0x40
    jump = 1'b1; jump_pc = 32'h40;
    tick();
    jump = 1'b0;
    mem_ready = 1'b1; mem_data = 32'h1111_1111;
    tick();
    check("c_fetch40_addr", mem_addr, 32'h40);
    mem_ready = 1'b0;
    tick();
    mem_ready = 1'b1; mem_data = 32'h02A0_0293;
    expect_word(32'h40, 32'h02A0_0293);
    stall = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("c_hold40_pc", if_pc, 32'h40);
    // Jump back to 0x40 while held and stalled: word dropped, cache probed
    jump = 1'b1; jump_pc = 32'h40;
    tick();
    jump = 1'b0; stall = 1'b0;
    check("c_lookup_req", {31'd0, mem_req}, 32'd0);
    check("c_lookup_ins", if_ins, c_NOP_INS);
    rdy_in = 1'b0;
    repeat (2) tick();
    check("c_frozen_req", {31'd0, mem_req}, 32'd0);
    check("c_frozen_ins", if_ins, c_NOP_INS);
    rdy_in = 1'b1;
    expect_word(32'h40, 32'h02A0_0293);
    tick();
    check("c_hit_pc", if_pc, 32'h40);
    check("c_hit_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("c_next_lookup_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("c_next_req", {31'd0, mem_req}, 32'd1);
    check("c_next_addr", mem_addr, 32'h44);
    // The first word at 0x40 was flushed by the jump, never latched
    if (sb_q.size() > 0) void'(sb_q.pop_front());
`else
    // Test 1: one IDLE cycle, then fetch at 0; async reset mid-request
    check("idle_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("fetch0_req", {31'd0, mem_req}, 32'd1);
    check("fetch0_addr", mem_addr, 32'h0);
    rst_in = 1'b1;
    #2;
    check("async_rst_req", {31'd0, mem_req}, 32'd0);
    check("async_rst_ins", if_ins, c_NOP_INS);
    check("async_rst_pc", if_pc, 32'h0);
    tick();
    rst_in = 1'b0;
    check("idle2_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("fetch0b_req", {31'd0, mem_req}, 32'd1);
    check("fetch0b_addr", mem_addr, 32'h0);

    // Test 2: first word, consumed immediately
    mem_ready = 1'b1; mem_data = 32'h0050_0093;
    expect_word(32'h0, 32'h0050_0093);
    tick();
    mem_ready = 1'b0;
    check("hold0_pc", if_pc, 32'h0);
    check("hold0_ins", if_ins, 32'h0050_0093);
    check("hold0_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("after0_ins", if_ins, c_NOP_INS);
    check("after0_req", {31'd0, mem_req}, 32'd1);
    check("after0_addr", mem_addr, 32'h4);

    // Test 3: latency of two cycles, then word held under stall
    repeat (2) tick();
    check("wait4_addr", mem_addr, 32'h4);
    mem_ready = 1'b1; mem_data = 32'h00A0_0113;
    stall = 1'b1;
    expect_word(32'h4, 32'h00A0_0113);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_pc", if_pc, 32'h4);
      check("stall_ins", if_ins, 32'h00A0_0113);
      check("stall_req", {31'd0, mem_req}, 32'd0);
      tick();
    end
    stall = 1'b0;
    tick();
    check("after4_req", {31'd0, mem_req}, 32'd1);
    check("after4_addr", mem_addr, 32'h8);

    // Test 4: jump while fetching 8 -> drain; second jump retargets
    jump = 1'b1; jump_pc = 32'h80;
    tick();
    check("drain_addr", mem_addr, 32'h8);
    check("drain_req", {31'd0, mem_req}, 32'd1);
    jump_pc = 32'h103;
    tick();
    jump = 1'b0;
    check("drain2_addr", mem_addr, 32'h8);
    mem_ready = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    check("redir_addr", mem_addr, 32'h100);
    check("redir_req", {31'd0, mem_req}, 32'd1);
    check("redir_ins", if_ins, c_NOP_INS);
    mem_ready = 1'b1; mem_data = 32'h0000_0513;
    expect_word(32'h100, 32'h0000_0513);
    tick();
    mem_ready = 1'b0;
    check("hold100_pc", if_pc, 32'h100);
    tick();
    check("after100_addr", mem_addr, 32'h104);

    // Test 5: jump on the same edge as mem_ready
    jump = 1'b1; jump_pc = 32'h200;
    mem_ready = 1'b1; mem_data = 32'hBADB_AD00;
    tick();
    jump = 1'b0; mem_ready = 1'b0;
    check("samejmp_ins", if_ins, c_NOP_INS);
    check("samejmp_pc", if_pc, 32'h0);
    check("samejmp_req", {31'd0, mem_req}, 32'd1);
    check("samejmp_addr", mem_addr, 32'h200);

    // PC wrap at 0xFFFFFFFC
    jump = 1'b1; jump_pc = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    check("wrap_drain_addr", mem_addr, 32'h200);
    mem_ready = 1'b1; mem_data = 32'h5555_5555;
    tick();
    mem_ready = 1'b0;
    check("wrap_fetch_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    mem_ready = 1'b1; mem_data = 32'h0010_0073;
    expect_word(32'hFFFF_FFFC, 32'h0010_0073);
    tick();
    mem_ready = 1'b0;
    check("wrap_hold_pc", if_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_next_addr", mem_addr, 32'h0);
    check("wrap_next_req", {31'd0, mem_req}, 32'd1);

    // rdy_in=0 freezes everything, including a returning word
    rdy_in = 1'b0;
    mem_ready = 1'b1; mem_data = 32'h0BAD_F00D;
    repeat (2) tick();
    check("frz_req", {31'd0, mem_req}, 32'd1);
    check("frz_addr", mem_addr, 32'h0);
    check("frz_ins", if_ins, c_NOP_INS);
    rdy_in = 1'b1;
    mem_data = 32'h00C0_0193;
    expect_word(32'h0, 32'h00C0_0193);
    tick();
    mem_ready = 1'b0;
    rdy_in = 1'b0;
    tick();
    check("frz_hold_pc", if_pc, 32'h0);
    check("frz_hold_ins", if_ins, 32'h00C0_0193);
    check("frz_hold_req", {31'd0, mem_req}, 32'd0);
    rdy_in = 1'b1;
    tick();
    check("frz_after_addr", mem_addr, 32'h4);
    check("frz_after_req", {31'd0, mem_req}, 32'd1);
`endif

    tick();
    check("sb_leftover", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
